// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, skid depth and occupancy encodings for the FIFO read controller
package fifo_pkg;

   localparam int FIFO_DATA_W = 6;
   localparam int FIFO_CNT_W  = 8;
   localparam int SKID_DEPTH  = 2;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry in-order skid buffer; occupancy is owned by the caller
module fifo_skid2
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  occ_e              occ_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic [DATA_W-1:0] head_o
);

   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;

   // Unused slots are kept at zero so the head reads 0 whenever the buffer is empty.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (occ_i == S_EMPTY) head_d = push_data_i;
            else if (occ_i == S_ONE) tail_d = push_data_i;
         end
         2'b01: begin
            head_d = tail_q;
            tail_d = '0;
         end
         2'b11: begin
            if (occ_i == S_TWO) begin
               head_d = tail_q;
               tail_d = push_data_i;
            end else begin
               head_d = push_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read issue, occupancy FSM and delivered-word counter
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int CNT_W  = FIFO_CNT_W
) (
   input  logic              clk,
   input  logic              RESET_L,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              pause,
   output logic              fifo_rd,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [CNT_W-1:0]  word_count
);

   occ_e             occ_q, occ_d;
   logic             rd_pending_q;
   logic [CNT_W-1:0] word_count_q;
   logic             pop;
   logic             capture;
   logic [2:0]       in_flight;

   assign pop     = (occ_q != S_EMPTY) & ~pause;
   assign capture = rd_pending_q;

   always_ff @(posedge clk) begin
      if (!RESET_L) begin
         occ_q        <= S_EMPTY;
         rd_pending_q <= 1'b0;
      end else begin
         occ_q        <= occ_d;
         rd_pending_q <= fifo_rd;
      end
   end

   always_comb begin
      occ_d = occ_q;
      case (occ_q)
         S_EMPTY: if (capture && !pop) occ_d = S_ONE;
         S_ONE: begin
            if (capture && !pop) occ_d = S_TWO;
            else if (pop && !capture) occ_d = S_EMPTY;
         end
         S_TWO:   if (pop && !capture) occ_d = S_ONE;
         default: occ_d = S_EMPTY;
      endcase
   end

   // A read is issued only if the word it returns still fits after in-flight reads land.
   always_comb begin
      in_flight = 3'(occ_q) + 3'(rd_pending_q) - 3'(pop);
      valid_out = (occ_q != S_EMPTY);
      fifo_rd   = RESET_L & ~fifo_empty & (in_flight < 3'(SKID_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!RESET_L) word_count_q <= '0;
      else if (pop) word_count_q <= word_count_q + CNT_W'(1);
   end

   assign word_count = word_count_q;

   fifo_skid2 #(
      .DATA_W(DATA_W)
   ) u_skid (
      .clk_i      (clk),
      .resetn_i   (RESET_L),
      .push_i     (capture),
      .pop_i      (pop),
      .occ_i      (occ_q),
      .push_data_i(fifo_data),
      .head_o     (data_out)
   );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - randomized and directed bench for fifo_rd_ctrl against a queue-based model
module tb_fifo_rd_ctrl;

   logic       clk;
   logic       RESET_L;
   logic       fifo_empty;
   logic [5:0] fifo_data;
   logic       pause;
   logic       fifo_rd;
   logic [5:0] data_out;
   logic       valid_out;
   logic [7:0] word_count;

   fifo_rd_ctrl #(.DATA_W(6), .CNT_W(8)) dut (
      .clk       (clk),
      .RESET_L   (RESET_L),
      .fifo_empty(fifo_empty),
      .fifo_data (fifo_data),
      .pause     (pause),
      .fifo_rd   (fifo_rd),
      .data_out  (data_out),
      .valid_out (valid_out),
      .word_count(word_count)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Bench-side FIFO: registered read data one cycle after fifo_rd.
   logic [5:0]  mem [0:1023];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   initial fifo_data = '0;
   assign fifo_empty = (wr_ptr == rd_ptr);
   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_data <= mem[rd_ptr % 1024];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [5:0] w);
      mem[wr_ptr % 1024] = w;
      wr_ptr++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the buffer as a queue of captured words plus one in-flight flag.
   logic [5:0] sb_q [$];
   logic [5:0] deliv_q [$];
   bit         pend = 1'b0;
   bit         check_en = 1'b0;
   logic [7:0] exp_cnt = '0;
   int         rd_pulses = 0;
   int         valid_cycles = 0;

   always @(negedge clk) begin
      bit         exp_valid;
      bit         exp_pop;
      logic [5:0] exp_data;
      bit         exp_rd;
      int         occ_sum;
      exp_valid = (sb_q.size() != 0);
      exp_pop   = exp_valid && !pause;
      exp_data  = exp_valid ? sb_q[0] : 6'd0;
      occ_sum   = sb_q.size() + (pend ? 1 : 0) - (exp_pop ? 1 : 0);
      exp_rd    = RESET_L && !fifo_empty && (occ_sum < 2);
      if (check_en) begin
         chk("valid_out", int'(valid_out), int'(exp_valid));
         chk("data_out", int'(data_out), int'(exp_data));
         chk("word_count", int'(word_count), int'(exp_cnt));
         chk("fifo_rd", int'(fifo_rd), int'(exp_rd));
      end
      if (fifo_rd) rd_pulses++;
      if (valid_out) valid_cycles++;
      if (valid_out && !pause) deliv_q.push_back(data_out);
      if (!RESET_L) begin
         sb_q.delete();
         pend     = 1'b0;
         exp_cnt  = '0;
         check_en = 1'b1;
      end else begin
         if (exp_pop) begin
            void'(sb_q.pop_front());
            exp_cnt = exp_cnt + 8'd1;
         end
         if (pend) sb_q.push_back(fifo_data);
         pend = exp_rd;
      end
   end

   task automatic wait_idle(input string nm);
      int quiet;
      int budget;
      quiet  = 0;
      budget = 3000;
      while (quiet < 3 && budget > 0) begin
         tick();
         budget--;
         if (fifo_empty && !valid_out && !fifo_rd) quiet++;
         else quiet = 0;
      end
      if (quiet < 3) chk({nm, "_timeout"}, 0, 1);
   endtask

   logic [5:0] bp_words [8];
   logic [5:0] st_words [4];
   logic [5:0] rs_words [3];
   int s_rd, s_val, s_dv;

   initial begin
      bp_words = '{6'b110010, 6'b101010, 6'b011001, 6'b000111,
                   6'b111000, 6'b100001, 6'b010110, 6'b110000};
      st_words = '{6'b100100, 6'b110110, 6'b010100, 6'b110000};
      rs_words = '{6'b001011, 6'b101101, 6'b011110};
      RESET_L = 1'b0;
      pause   = 1'b0;
      repeat (3) tick();
      RESET_L = 1'b1;
      chk("reset_valid", int'(valid_out), 0);
      chk("reset_data", int'(data_out), 0);
      chk("reset_count", int'(word_count), 0);
      chk("reset_rd", int'(fifo_rd), 0);

      s_rd = rd_pulses; s_val = valid_cycles;
      repeat (10) tick();
      chk("empty_rd_pulses", rd_pulses - s_rd, 0);
      chk("empty_valid_cycles", valid_cycles - s_val, 0);
      chk("empty_data", int'(data_out), 0);

      s_rd = rd_pulses; s_val = valid_cycles; s_dv = deliv_q.size();
      push(6'b010010);
      repeat (8) tick();
      chk("single_rd_pulses", rd_pulses - s_rd, 1);
      chk("single_valid_cycles", valid_cycles - s_val, 1);
      chk("single_count", int'(word_count), 1);
      chk("single_delivered", deliv_q.size() - s_dv, 1);
      if (deliv_q.size() > s_dv) chk("single_word", int'(deliv_q[s_dv]), 'b010010);

      s_val = valid_cycles; s_dv = deliv_q.size();
      for (int i = 0; i < 4; i++) push(st_words[i]);
      repeat (10) tick();
      chk("stream_valid_cycles", valid_cycles - s_val, 4);
      chk("stream_count", int'(word_count), 5);
      chk("stream_delivered", deliv_q.size() - s_dv, 4);
      for (int i = 0; i < 4; i++)
         if (deliv_q.size() > s_dv + i) chk("stream_order", int'(deliv_q[s_dv + i]), int'(st_words[i]));

      pause = 1'b1;
      s_rd = rd_pulses; s_dv = deliv_q.size();
      for (int i = 0; i < 8; i++) push(bp_words[i]);
      repeat (6) tick();
      chk("bp_rd_pulses", rd_pulses - s_rd, 2);
      chk("bp_held_data", int'(data_out), 'b110010);
      chk("bp_held_valid", int'(valid_out), 1);
      chk("bp_rd_in_two", int'(fifo_rd), 0);
      pause = 1'b0;
      repeat (14) tick();
      chk("bp_delivered", deliv_q.size() - s_dv, 8);
      for (int i = 0; i < 8; i++)
         if (deliv_q.size() > s_dv + i) chk("bp_order", int'(deliv_q[s_dv + i]), int'(bp_words[i]));
      chk("bp_count", int'(word_count), 13);

      for (int c = 0; c < 1200; c++) begin
         if ((c % 50) < 10) pause = 1'b1;
         else pause = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0 && (wr_ptr - rd_ptr) < 900) push(6'($urandom_range(0, 63)));
         tick();
      end
      pause = 1'b0;
      wait_idle("random_drain");

      s_dv = deliv_q.size();
      for (int i = 0; i < 3; i++) push(rs_words[i]);
      tick();
      RESET_L = 1'b0;
      tick();
      RESET_L = 1'b1;
      chk("midreset_valid", int'(valid_out), 0);
      chk("midreset_data", int'(data_out), 0);
      chk("midreset_count", int'(word_count), 0);
      repeat (10) tick();
      chk("midreset_delivered", deliv_q.size() - s_dv, 2);
      if (deliv_q.size() > s_dv + 1) begin
         chk("midreset_first", int'(deliv_q[s_dv]), int'(rs_words[1]));
         chk("midreset_second", int'(deliv_q[s_dv + 1]), int'(rs_words[2]));
      end
      chk("midreset_count2", int'(word_count), 2);

      s_dv = deliv_q.size();
      for (int i = 0; i < 254; i++) push(6'(i));
      wait_idle("wrap_drain");
      chk("wrap_delivered", deliv_q.size() - s_dv, 254);
      chk("wrap_count", int'(word_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have: RESET_L  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: fifo_empty  input  1  FIFO empty flag.
REQ-004 SHALL have: fifo_data  input  6  FIFO read data, valid the cycle after fifo_rd.
REQ-005 SHALL have: pause  input  1  downstream back-pressure; high = not accepting.
REQ-006 SHALL have: fifo_rd  output  1  FIFO pop request.
REQ-007 SHALL have: data_out  output  6  head word presented downstream.
REQ-008 SHALL have: valid_out  output  1  data_out holds a word.
REQ-009 SHALL have: word_count  output  8  words delivered since reset.
REQ-010 SHALL take parameters: DATA_W, default 6, word width; CNT_W, default 8, word_count width.

Function
REQ-011 SHALL hold a 2-entry skid buffer; occupancy FSM states S_EMPTY(0), S_ONE(1), S_TWO(2).
REQ-012 SHALL define pop = valid_out & !pause; a word transfers downstream on each cycle pop is high.
REQ-013 SHALL register rd_pending = fifo_rd of the previous cycle.
REQ-014 SHALL drive fifo_rd = RESET_L & !fifo_empty & (occ + rd_pending - pop < 2), combinationally.
REQ-015 SHALL never assert fifo_rd while fifo_empty is high (no underflow).
REQ-016 SHALL capture fifo_data into the buffer tail on every cycle rd_pending is high; read-to-valid latency 2 cycles from fifo_rd.
REQ-017 SHALL drive valid_out = (occ != 0) and data_out = head entry, both from registers.
REQ-018 SHALL keep data_out and valid_out stable while pause is high and valid_out is high.
REQ-019 SHALL handle capture and pop in the same cycle: occupancy unchanged, head advances, new word appended in order.
REQ-020 SHALL sustain one word per cycle when FIFO non-empty and pause low.
REQ-021 SHALL deliver words strictly in FIFO order; no loss, duplication or reordering across pause.
REQ-022 SHALL transition S_EMPTY->S_ONE on capture without pop; S_ONE->S_TWO on capture without pop; S_TWO->S_ONE on pop without capture; S_ONE->S_EMPTY on pop without capture; otherwise hold.
REQ-023 SHALL increment word_count on each pop, wrapping 255->0.
REQ-024 SHALL drive data_out = 0 while valid_out is low.

Reset
REQ-025 SHALL, on posedge clk with RESET_L low, set occ=S_EMPTY, rd_pending=0, buffer entries=0, data_out=0, valid_out=0, word_count=0.
REQ-026 SHALL hold fifo_rd low during the whole of reset.
REQ-027 SHALL discard any read in flight when reset asserts mid-operation; data returned the next cycle is not captured.
REQ-028 SHALL issue the first fifo_rd no earlier than the first cycle after RESET_L is sampled high.

Structure
REQ-029 SHALL take DATA_W, CNT_W, SKID_DEPTH=2 and FSM state encodings from shared package fifo_pkg.
REQ-030 SHALL instantiate one sub-module fifo_skid2 (2-entry in-order buffer with push/pop/occupancy); FSM, read issue and counter stay in fifo_rd_ctrl.

Verification
REQ-031 Bench SHALL pair fifo_rd_ctrl with the team FIFO, clk period 4 time units, dump to fifo_rd_ctrl.vcd.
REQ-032 Single word: write 6'b010010, pause=0 -> one fifo_rd pulse, valid_out high 1 cycle with data_out=010010, word_count=1.
REQ-033 Stream: write 100100,110110,010100,110000 back-to-back -> four consecutive valid_out cycles, in order, word_count=5.
REQ-034 Back-pressure: fill 8 words 110010..110000, pause=1 for 6 cycles -> exactly 2 fifo_rd pulses, data_out held 110010, fifo_rd=0 while S_TWO; release -> remaining words in order, none lost.
REQ-035 Empty guard: FIFO empty for 10 cycles -> fifo_rd never high, valid_out 0, data_out 0.
REQ-036 Reset mid-stream: RESET_L low 1 cycle during a read in flight -> all outputs 0 next cycle, the in-flight word not delivered, word_count restarts at 0; 256 pops -> word_count wraps to 0.
